// File: rtl/button_decoder_pkg.sv
// Shared types, defaults and bit-vector helpers for the button event decoder.
package button_decoder_pkg;

    localparam int unsigned DEF_N_BUTTONS       = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam bit          DEF_ACTIVE_LOW      = 1'b1;
    localparam int unsigned DEF_REPEAT_DELAY    = 64;
    localparam int unsigned DEF_REPEAT_PERIOD   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_CHORD = 2'd2
    } state_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic int unsigned onehot_index(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: polarity normalise, 2-flop synchroniser, stable-count debounce.
module button_debouncer
    import button_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic newClock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = ACTIVE_LOW ? ~raw : raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Count consecutive disagreeing cycles; flip once the run is long enough.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
        end
    end

    always_ff @(posedge newClock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_event_decoder.sv
// Debounced N-button front end producing single-cycle key events with the button index.
// Optional auto-repeat while a single button is held: define BUTTON_AUTO_REPEAT_EN.
module button_event_decoder
    import button_decoder_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = DEF_N_BUTTONS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    localparam int unsigned CODE_W         = (N_BUTTONS > 2) ? $clog2(N_BUTTONS) : 1
) (
    input  logic                 newClock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic                 event_valid,
    output logic [CODE_W-1:0]    event_code,
    output logic                 pressed,
    output logic                 multi_press
);

    if (N_BUTTONS < 2 || N_BUTTONS > 32) begin : g_bad_n
        $error("N_BUTTONS must be in 2..32");
    end
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_timing
        $error("cycle parameters must be at least 1");
    end

    logic [N_BUTTONS-1:0] deb;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_deb (
            .newClock (newClock),
            .reset    (reset),
            .raw      (buttons[i]),
            .level    (deb[i])
        );
    end

    state_t            state_q, state_d;
    logic              ev_q, ev_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              pressed_q, pressed_d;
    logic              multi_q, multi_d;
    int unsigned       pop;
    logic [CODE_W-1:0] idx;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W  = $clog2(REP_MAX + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              first_q, first_d;
`endif

    always_comb begin
        pop     = popcount(32'(deb));
        idx     = CODE_W'(onehot_index(32'(deb)));
        state_d = state_q;
        ev_d    = 1'b0;
        code_d  = code_q;
`ifdef BUTTON_AUTO_REPEAT_EN
        hold_d  = '0;
        first_d = 1'b1;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pop == 1) begin
                    state_d = ST_HELD;
                    ev_d    = 1'b1;
                    code_d  = idx;
                end else if (pop >= 2) begin
                    state_d = ST_CHORD;
                end
            end
            ST_HELD: begin
                if (pop == 0) begin
                    state_d = ST_IDLE;
                end else if (pop >= 2) begin
                    state_d = ST_CHORD;
                end else if (idx != code_q) begin
                    ev_d   = 1'b1;
                    code_d = idx;
                end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                    // Same button still held: first repeat after DELAY, then every PERIOD.
                    first_d = first_q;
                    if (hold_q == HOLD_W'((first_q ? REPEAT_DELAY : REPEAT_PERIOD) - 1)) begin
                        ev_d    = 1'b1;
                        first_d = 1'b0;
                    end else begin
                        hold_d = HOLD_W'(hold_q + HOLD_W'(1));
                    end
`endif
                end
            end
            ST_CHORD: begin
                if (pop == 0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pressed_d = (state_d == ST_HELD);
        multi_d   = (state_d == ST_CHORD);
    end

    always_ff @(posedge newClock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ev_q      <= 1'b0;
            code_q    <= '0;
            pressed_q <= 1'b0;
            multi_q   <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            hold_q    <= '0;
            first_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            ev_q      <= ev_d;
            code_q    <= code_d;
            pressed_q <= pressed_d;
            multi_q   <= multi_d;
`ifdef BUTTON_AUTO_REPEAT_EN
            hold_q    <= hold_d;
            first_q   <= first_d;
`endif
        end
    end

    assign event_valid = ev_q;
    assign event_code  = code_q;
    assign pressed     = pressed_q;
    assign multi_press = multi_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: behavioural model + per-cycle compare, directed pins, random stimulus.
module tb_button_event_decoder;

    localparam int unsigned N  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned RP = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] buttons = '1;
    logic         event_valid;
    logic [1:0]   event_code;
    logic         pressed;
    logic         multi_press;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .newClock    (clk),
        .reset       (reset),
        .buttons     (buttons),
        .event_valid (event_valid),
        .event_code  (event_code),
        .pressed     (pressed),
        .multi_press (multi_press)
    );

    // Reference model state: history of pressed samples and spec-level key mode.
    logic [N-1:0] hist [$];
    logic [N-1:0] m_deb;
    int           m_mode;   // 0 nothing held, 1 single key, 2 chord
    int           m_code;
    bit           m_ev;
    int           m_since;
    bit           m_first;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= D; i++) hist.push_back('0);
        m_deb   = '0;
        m_mode  = 0;
        m_code  = 0;
        m_ev    = 1'b0;
        m_since = 0;
        m_first = 1'b1;
    endtask

    task automatic model_step();
        int ones;
        int key;
        ones = $countones(m_deb);
        key  = 0;
        for (int i = 0; i < N; i++) if (m_deb[i]) key = i;
        m_ev = 1'b0;
        if (ones == 0) begin
            m_mode = 0;
        end else if (ones >= 2) begin
            m_mode = 2;
        end else if (m_mode == 0 || (m_mode == 1 && key != m_code)) begin
            m_mode  = 1;
            m_ev    = 1'b1;
            m_code  = key;
            m_since = 0;
            m_first = 1'b1;
        end else if (m_mode == 1) begin
`ifdef BUTTON_AUTO_REPEAT_EN
            m_since++;
            if (m_since == (m_first ? RD : RP)) begin
                m_ev    = 1'b1;
                m_since = 0;
                m_first = 1'b0;
            end
`endif
        end
        if (m_mode != 1) begin
            m_since = 0;
            m_first = 1'b1;
        end
        // A channel's debounced level flips once its last D synchronised samples all disagree.
        for (int c = 0; c < N; c++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (hist[j][c] == m_deb[c]) all_diff = 1'b0;
            if (all_diff) m_deb[c] = ~m_deb[c];
        end
        hist.push_back(~buttons);
        void'(hist.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("event_valid", int'(event_valid), int'(m_ev));
            check("event_code", int'(event_code), m_code);
            check("pressed", int'(pressed), int'(m_mode == 1));
            check("multi_press", int'(multi_press), int'(m_mode == 2));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Runs n cycles; reports event count, first event cycle/code and pressed-low cycles.
    task automatic watch(input int n, output int cnt, output int first, output int code,
                         output int pr_low);
        cnt = 0; first = -1; code = -1; pr_low = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (event_valid) begin
                if (cnt == 0) begin
                    first = i;
                    code  = int'(event_code);
                end
                cnt++;
            end
            if (!pressed) pr_low++;
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        buttons = '1;
        #1;
        check("rst_event_valid", int'(event_valid), 0);
        check("rst_event_code", int'(event_code), 0);
        check("rst_pressed", int'(pressed), 0);
        check("rst_multi", int'(multi_press), 0);
        tick(3);
        reset = 1'b0;
    endtask

    initial begin
        int cnt, first, code, prl, tot;
        tick(2);
        do_reset();

        // Clean press then release.
        buttons = 4'b1110;
        watch(20, cnt, first, code, prl);
        check("clean_count", cnt, 1);
        check("clean_cycle", first, 7);
        check("clean_code", code, 0);
        check("clean_pressed_low", prl, 6);
        buttons = 4'b1111;
        watch(10, cnt, first, code, prl);
        check("release_pressed_low", prl, 4);

        // Bounce on bit 2, settling pressed.
        do_reset();
        tot = 0;
        for (int s = 0; s < 6; s++) begin
            buttons = (s % 2 == 0) ? 4'b1011 : 4'b1111;
            watch(2, cnt, first, code, prl);
            tot += cnt;
        end
        check("bounce_early_events", tot, 0);
        buttons = 4'b1011;
        watch(20, cnt, first, code, prl);
        check("bounce_count", cnt, 1);
        check("bounce_cycle", first, 7);
        check("bounce_code", code, 2);

        // Chord sequence.
        do_reset();
        buttons = 4'b1100;
        watch(10, cnt, first, code, prl);
        check("chord_a_events", cnt, 0);
        check("chord_a_multi", int'(multi_press), 1);
        buttons = 4'b1101;
        watch(10, cnt, first, code, prl);
        check("chord_b_events", cnt, 0);
        check("chord_b_multi", int'(multi_press), 1);
        buttons = 4'b1111;
        watch(10, cnt, first, code, prl);
        check("chord_c_events", cnt, 0);
        check("chord_c_multi", int'(multi_press), 0);
        buttons = 4'b1011;
        watch(10, cnt, first, code, prl);
        check("chord_d_count", cnt, 1);
        check("chord_d_code", code, 2);

        // Direct switch between single keys without an idle visit.
        do_reset();
        buttons = 4'b1110;
        watch(10, cnt, first, code, prl);
        check("switch_first_code", code, 0);
        buttons = 4'b1011;
        watch(10, cnt, first, code, prl);
        check("switch_count", cnt, 1);
        check("switch_cycle", first, 7);
        check("switch_code", code, 2);
        check("switch_pressed_low", prl, 0);

        // Reset asserted mid-press.
        do_reset();
        buttons = 4'b0111;
        tick(10);
        reset = 1'b1;
        #1;
        check("midrst_event_valid", int'(event_valid), 0);
        check("midrst_code", int'(event_code), 0);
        check("midrst_pressed", int'(pressed), 0);
        check("midrst_multi", int'(multi_press), 0);
        tick(2);
        reset = 1'b0;
        watch(12, cnt, first, code, prl);
        check("midrst_count", cnt, 1);
        check("midrst_cycle", first, 7);
        check("midrst_code_after", code, 3);

`ifdef BUTTON_AUTO_REPEAT_EN
        do_reset();
        buttons = 4'b1101;
        tot = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 31) buttons = 4'b1111;
            @(posedge clk);
            #1;
            if (event_valid) begin
                check("repeat_cycle", i, 7 + ((tot == 0) ? 0 : (RD + (tot - 1) * RP)));
                check("repeat_code", int'(event_code), 1);
                tot++;
            end
            #1;
        end
        check("repeat_count", tot, 7);
`endif

        // Randomised segments, checked every cycle by the compare process.
        do_reset();
        for (int s = 0; s < 400; s++) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0) buttons = 4'b1111;
            else if (r == 3) buttons = 4'($urandom_range(0, 15));
            else buttons = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                tick(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end
            tick(int'($urandom_range(1, 12)));
        end

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Parametrised, debounced button front end for the calculator. It turns N raw switch or key inputs into clean, single-cycle key events carrying the button index. It replaces the combinational one-of-four decoder, which had no debounce and no edge detection. Downstream logic consumes `event_valid`/`event_code` directly; no external debounce or pulse stage is required.

## Interface
Parameters:
- `N_BUTTONS`, 4: number of button inputs; must be ≥2.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a debounced level changes; must be ≥1.
- `ACTIVE_LOW`, 1: 1 means a raw 0 is "pressed"; 0 means a raw 1 is "pressed".
- `REPEAT_DELAY`, 64: hold cycles before the first auto-repeat. Used only with `BUTTON_AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, 16: cycles between later auto-repeats. Used only with `BUTTON_AUTO_REPEAT_EN`.
- Derived: `CODE_W = max(1, $clog2(N_BUTTONS))`.

Ports:
- `newClock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `buttons`  in  N_BUTTONS  raw, asynchronous button/switch levels.
- `event_valid`  out  1  one-cycle pulse per accepted press (and per repeat).
- `event_code`  out  CODE_W  index of the pressed button; updated only when `event_valid` is high, otherwise held.
- `pressed`  out  1  high while the FSM is in HELD.
- `multi_press`  out  1  high while the FSM is in CHORD.

## Operation
- Input conditioning:
  - Polarity: each input is normalised to an active-high "pressed" bit.
  - Synchronisation: a 2-flop synchroniser is applied per channel.
- Debounce (per channel):
  - A counter runs while the synchronised level differs from the debounced level; it resets to 0 on any cycle where the two match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- FSM on the debounced vector `d` (popcount p):
  - IDLE: p=0 stays. p=1 goes to HELD and emits an event with the index. p≥2 goes to CHORD with no event.
  - HELD: same single bit stays. p=0 goes to IDLE. p≥2 goes to CHORD with no event. A different single bit (simultaneous release plus press) emits an event with the new index and stays in HELD.
  - CHORD: no events. Only p=0 returns to IDLE. Dropping back to p=1 stays in CHORD, so a chord never produces a late event.
- At most one event per cycle. Ties cannot occur, because events are emitted only when p=1.

## Timing
- Reset values:
  - Outputs: `event_valid`=0, `event_code`=0, `pressed`=0, `multi_press`=0.
  - Internal: synchroniser flops and debounced levels = released; counters = 0; FSM = IDLE.
- Latency: a raw level stable from cycle 0 produces `event_valid` in cycle `DEBOUNCE_CYCLES+3` (2 synchroniser cycles + debounce + 1 registered FSM output). Release has the same latency to IDLE.
- All outputs are registered. `pressed`/`multi_press` change in the same cycle as the corresponding event or state change.
- Reset asserted mid-press clears everything immediately. After reset deasserts, a still-held button is treated as a new press and fires after `DEBOUNCE_CYCLES+3` cycles.

## Configuration
- `BUTTON_AUTO_REPEAT_EN` defined:
  - In HELD, a hold counter starts at the entry event.
  - After `REPEAT_DELAY` cycles, an event with the same code is emitted, then one every `REPEAT_PERIOD` cycles while held.
  - The counter clears on leaving HELD and on a code change. Never active in CHORD.
- Undefined: exactly one event per press, no hold counter logic, and the REPEAT parameters are ignored.

## Structure
- Package `button_decoder_pkg`:
  - FSM state enum: IDLE, HELD, CHORD.
  - `onehot_index`/popcount functions.
  - Default parameter constants.
- Sub-module `button_debouncer`: one channel (synchroniser + counter + debounced level). Instantiated N_BUTTONS times via generate.

## Test plan
All scenarios use N_BUTTONS=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
- Clean press: `buttons`=4'b1110 from cycle 0, held 20 cycles -> single `event_valid` at cycle 7 with `event_code`=0; `pressed`=1 from cycle 7 until 7 cycles after release.
- Bounce: bit 2 toggles every 2 cycles for 12 cycles, then stays 0 -> exactly one event with `event_code`=2, 7 cycles after the last toggle.
- Chord: 4'b1100, then 4'b1101, then 4'b1111, then 4'b1011 -> no events during the chord; `multi_press`=1 until all are released; then one event with `event_code`=2.
- Reset mid-press: hold 4'b0111, assert `reset` at cycle 10 for 2 cycles -> all outputs 0 immediately; an event with `event_code`=3 occurs 7 cycles after reset deasserts.
- Direct switch: debounced vector changes from 0001 to 0100 in one cycle -> the second event has `event_code`=2, with no IDLE visit.
- With `BUTTON_AUTO_REPEAT_EN`, REPEAT_DELAY=8, REPEAT_PERIOD=4, hold 4'b1101 for 30 cycles -> events at cycles 7, 15, 19, 23, 27, 31, 35 (the hold runs 30 cycles from cycle 0 and the debounced release occurs at cycle 37), all with `event_code`=1.
